f_pc_gen: RTL
=============

Name: f_pc_gen

Overview:
- Fetch-stage PC generator. It combines next-PC selection (sequential, j/jal, jr/jalr, conditional branch, eret, exception vector) with the PC register and an instruction-memory request handshake.
- Redirects that arrive while fetch cannot advance are buffered in a one-entry pending-redirect register and applied later.
- Sits between the D-stage branch/jump decode and IMEM, and drives F_pc to the F/D pipeline register.

Parameters:
- WIDTH, 32, PC/address width (>=28).
- RESET_PC, 32'h0000_3000, PC value while reset is asserted and after release.
- EXC_VEC, 32'h0000_4180, exception/interrupt handler entry.
- ERET_PLUS4, 1, 1: eret target = EPC+4; 0: eret target = EPC.
- IMEM_LO, 32'h0000_3000, lowest legal fetch address.
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall from hazard unit; freezes PC
- req  in  1  exception/interrupt taken (from CP0), one-cycle pulse
- eret  in  1  eret in D, one-cycle pulse
- epc  in  WIDTH  EPC from CP0
- br_sel  in  3  BR_pc4 / BR_addr / BR_reg / BR_branch (const.v encodings)
- b_jump  in  1  branch condition true (D stage)
- d_pc  in  WIDTH  PC of instruction in D
- imm26  in  26  D-stage instruction immediate field
- rs  in  WIDTH  forwarded rs value (D stage)
- imem_ready  in  1  IMEM accepts/returns the fetch this cycle
- imem_valid  out  1  fetch request valid
- imem_addr  out  WIDTH  fetch address (= F_pc)
- F_pc  out  WIDTH  current fetch PC
- F_adel  out  1  fetch address error for current F_pc
- redirect_pending  out  1  pending-redirect register occupied

Behaviour:
- Reset (async, reset_n=0): F_pc=RESET_PC, pending empty, redirect_pending=0. imem_valid=0 while reset_n=0, then follows the rule below. F_adel reflects RESET_PC.
- F_adel = (F_pc[1:0]!=0) | (F_pc<IMEM_LO) | (F_pc>IMEM_HI). This is combinational from F_pc.
- imem_valid = reset_n & ~F_adel. imem_addr = F_pc.
- fetch_done = imem_ready | F_adel. An illegal address is never sent to IMEM and counts as done, so CP0 can raise AdEL.
- Redirect target, by priority:
  - req: EXC_VEC.
  - eret: EPC + (ERET_PLUS4 ? 4 : 0).
  - BR_addr: {d_pc[W-1:28], imm26, 2'b00}.
  - BR_reg: rs.
  - BR_branch & b_jump: d_pc + 4 + (sext(imm26[15:0])<<2).
  - Otherwise: no redirect. All adds wrap modulo 2^WIDTH.
- Pending register: one entry, holding target and an is_req flag.
- The PC updates on a rising edge when advance is true:
  - advance = fetch_done & (~stall | req_any).
  - req_any = req | pending.is_req.
  - req overrides stall (flush semantics).
- Next F_pc when advancing:
  - live req present: EXC_VEC.
  - else pending occupied: pending target.
  - else live redirect present: live redirect target.
  - else: F_pc+4.
  - Pending is cleared in the same edge it is consumed.
- When not advancing and a live redirect is present, the redirect is written to pending.
  - A live req always overwrites pending.
  - A live non-req redirect writes only if pending is empty or not is_req.
  - A newer D redirect replaces an older non-req one.
- When not advancing and no live redirect: PC and pending both hold.
- Simultaneous req+eret: req wins. Branch with b_jump=0 under BR_branch: no redirect.
- Delay slot: redirects do not squash the instruction already fetched. Squash/flush of F/D is done outside this block.
- reset_n asserted mid-operation (including while pending is occupied or a fetch is waiting): immediate return to the reset state; pending is discarded.

Test Plan:
- Release reset, imem_ready=1, no redirects for 3 cycles -> F_pc 0x3000, 0x3004, 0x3008, 0x300C. imem_valid=1, F_adel=0.
- d_pc=0x3010, br_sel=BR_branch, b_jump=1, imm26[15:0]=0xFFFE -> next F_pc=0x300C. Same with b_jump=0 -> F_pc+4.
- imem_ready=0 for 3 cycles; br_sel=BR_reg with rs=0x3400 in cycle 1 -> redirect_pending=1, F_pc held. First imem_ready=1 -> F_pc=0x3400, redirect_pending=0.
- stall=1 with req pulse -> F_pc=0x4180 next edge despite stall. eret with epc=0x3020 -> 0x3024 (ERET_PLUS4=1), or 0x3020 with ERET_PLUS4=0.
- BR_reg with rs=0x3002, then rs=0x7000 -> F_adel=1, imem_valid=0, PC advances without imem_ready. Next-cycle req -> 0x4180.
- Pending non-req redirect queued, then req arrives while still blocked -> pending overwritten, final F_pc=0x4180. Assert reset_n=0 mid-wait -> F_pc=0x3000 immediately, redirect_pending=0.

Source files
------------

// File: rtl/f_pc_gen_if.sv
// Fetch-side IMEM request channel: address/valid out of the PC generator,
// ready back from instruction memory.
interface f_pc_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             imem_valid;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;

    modport master (
        output imem_valid,
        output imem_addr,
        input  imem_ready
    );

    modport slave (
        input  imem_valid,
        input  imem_addr,
        output imem_ready
    );
endinterface

// File: rtl/f_pc_gen.sv
// Fetch-stage PC generator: next-PC selection, PC register, IMEM handshake
// and a one-entry pending-redirect buffer for redirects seen while blocked.
module f_pc_gen #(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_PC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0]  EXC_VEC    = WIDTH'(32'h0000_4180),
    parameter bit                ERET_PLUS4 = 1'b1,
    parameter logic [WIDTH-1:0]  IMEM_LO    = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0]  IMEM_HI    = WIDTH'(32'h0000_6FFC)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic [2:0]       br_sel,
    input  logic             b_jump,
    input  logic [WIDTH-1:0] d_pc,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] rs,
    f_pc_gen_if.master       imem,
    output logic [WIDTH-1:0] F_pc,
    output logic             F_adel,
    output logic             redirect_pending
);

    localparam logic [2:0] BR_PC4    = 3'd0;
    localparam logic [2:0] BR_ADDR   = 3'd1;
    localparam logic [2:0] BR_REG    = 3'd2;
    localparam logic [2:0] BR_BRANCH = 3'd3;

    localparam int unsigned BR_EXT_W = WIDTH - 18;

    // Misaligned or outside the IMEM window.
    function automatic logic addr_err(input logic [WIDTH-1:0] pc);
        addr_err = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
    endfunction

    logic [WIDTH-1:0] r_pc;
    logic             r_adel;
    logic             r_pend_vld;
    logic             r_pend_req;
    logic [WIDTH-1:0] r_pend_tgt;

    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_br_off;
    logic [WIDTH-1:0] w_eret_tgt;
    logic             w_live_vld;
    logic [WIDTH-1:0] w_live_tgt;
    logic             w_req_any;
    logic             w_fetch_done;
    logic             w_advance;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             w_pend_vld_nxt;
    logic             w_pend_req_nxt;
    logic [WIDTH-1:0] w_pend_tgt_nxt;

    assign w_seq_pc   = r_pc + WIDTH'(4);
    assign w_br_off   = {{BR_EXT_W{imm26[15]}}, imm26[15:0], 2'b00};
    assign w_eret_tgt = epc + (ERET_PLUS4 ? WIDTH'(4) : WIDTH'(0));

    // Live redirect from CP0 / D stage, highest priority first.
    always_comb begin
        w_live_vld = 1'b0;
        w_live_tgt = '0;
        if (req) begin
            w_live_vld = 1'b1;
            w_live_tgt = EXC_VEC;
        end else if (eret) begin
            w_live_vld = 1'b1;
            w_live_tgt = w_eret_tgt;
        end else begin
            case (br_sel)
                BR_ADDR: begin
                    w_live_vld = 1'b1;
                    w_live_tgt = {d_pc[WIDTH-1:28], imm26, 2'b00};
                end
                BR_REG: begin
                    w_live_vld = 1'b1;
                    w_live_tgt = rs;
                end
                BR_BRANCH: begin
                    w_live_vld = b_jump;
                    w_live_tgt = d_pc + WIDTH'(4) + w_br_off;
                end
                BR_PC4:  w_live_vld = 1'b0;
                default: w_live_vld = 1'b0;
            endcase
        end
    end

    // An illegal fetch address never goes to IMEM and retires immediately.
    assign w_req_any    = req | (r_pend_vld & r_pend_req);
    assign w_fetch_done = imem.imem_ready | r_adel;
    assign w_advance    = w_fetch_done & (~stall | w_req_any);

    // Next PC and pending-register update.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_req_nxt = r_pend_req;
        w_pend_tgt_nxt = r_pend_tgt;
        if (w_advance) begin
            w_pend_vld_nxt = 1'b0;
            w_pend_req_nxt = 1'b0;
            if (req) begin
                w_pc_nxt = EXC_VEC;
            end else if (r_pend_vld) begin
                w_pc_nxt = r_pend_tgt;
            end else if (w_live_vld) begin
                w_pc_nxt = w_live_tgt;
            end else begin
                w_pc_nxt = w_seq_pc;
            end
        end else if (w_live_vld) begin
            // A queued exception is never displaced by an ordinary redirect.
            if (req || !r_pend_vld || !r_pend_req) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_req_nxt = req;
                w_pend_tgt_nxt = w_live_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_adel     <= addr_err(RESET_PC);
            r_pend_vld <= 1'b0;
            r_pend_req <= 1'b0;
            r_pend_tgt <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_adel     <= addr_err(w_pc_nxt);
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_req <= w_pend_req_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
        end
    end

    assign F_pc             = r_pc;
    assign F_adel           = r_adel;
    assign redirect_pending = r_pend_vld;
    assign imem.imem_addr   = r_pc;
    assign imem.imem_valid  = reset_n & ~r_adel;

endmodule
